rcb_ram_ctrl: RTL

- Responder end of the host write-request/done handshake (hpb_wr_req/addr/data/byte_en in, rcb_wr_done out).
- One instance per RAM control block (symbol, price, volume, order).
- Owns a single-port RAM and arbitrates between lookup-pipeline reads (priority) and host configuration writes, with a starvation guard on the write side.
- Returns read data at a fixed latency.

---
 rtl/tts_pkg.sv | 8 +
 rtl/rcb_sp_ram.sv | 42 ++++
 rtl/rcb_ram_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/tts_pkg.sv
// tts_pkg: shared types, limits and helpers for the RAM control blocks
package tts_pkg;
  typedef enum logic [2:0] {IDLE, PEND, COMMIT, DONE, HOLD} t_rcb_wr_state;
  localparam int RCB_MAX_RD_LATENCY = 4;
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/rcb_sp_ram.sv
// rcb_sp_ram: single-port byte-lane RAM, registered read padded to RD_LATENCY
// Lanes may be wider than 8 bits so a per-byte parity bit can ride along (RCB_PARITY_EN).
module rcb_sp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int LW = DATA_WIDTH / BE_WIDTH;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] q [RD_LATENCY];
  always_ff @(posedge clk)
    if (wr_en)
      for (int i = 0; i < BE_WIDTH; i++)
        if (wr_be[i]) mem[addr][i*LW +: LW] <= wr_data[i*LW +: LW];
  // each stage only loads on valid, so the output holds its last value
  always_ff @(posedge clk)
    if (!reset_n) begin
      vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) q[i] <= '0;
    end else begin
      vld[0] <= rd_en;
      if (rd_en) q[0] <= mem[addr];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) q[i] <= q[i-1];
      end
    end
  assign rd_valid = vld[RD_LATENCY-1];
  assign rd_data  = q[RD_LATENCY-1];
endmodule

// File: rtl/rcb_ram_ctrl.sv
// rcb_ram_ctrl: RAM control block arbitrating lookup reads over host writes
// Optional per-byte even parity storage and checking under RCB_PARITY_EN.
module rcb_ram_ctrl
  import tts_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hpb_wr_req,
  input  logic [ADDR_WIDTH-1:0]   hpb_wr_addr,
  input  logic [DATA_WIDTH-1:0]   hpb_wr_data,
  input  logic [DATA_WIDTH/8-1:0] hpb_wr_byte_en,
  output logic                    rcb_wr_done,
  input  logic                    rd_req,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data
`ifdef RCB_PARITY_EN
  ,
  output logic                    rd_parity_err
`endif
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
`ifdef RCB_PARITY_EN
  localparam int RW = DATA_WIDTH + BW;
`else
  localparam int RW = DATA_WIDTH;
`endif
  if (RD_LATENCY < 1 || RD_LATENCY > RCB_MAX_RD_LATENCY) begin : g_bad_latency
    $error("rcb_ram_ctrl: RD_LATENCY out of range");
  end
  t_rcb_wr_state state, nxt;
  logic [CW-1:0] starve_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [BW-1:0] wr_be_q;
  logic [RW-1:0] ram_wdata, ram_rdata;
  logic starve_max, rd_en, wr_en;
  assign starve_max  = starve_cnt == CW'(STARVE_LIMIT - 1);
  assign rd_ready    = state != COMMIT;
  assign rcb_wr_done = state == DONE;
  assign wr_en       = state == COMMIT;
  assign rd_en       = rd_req && rd_ready;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= nxt;
      starve_cnt <= state == DONE ? '0 :
                    (state == PEND && rd_req && !starve_max) ? starve_cnt + 1'b1 : starve_cnt;
    end
  always_ff @(posedge clk)
    if (state == IDLE && hpb_wr_req) begin
      wr_addr_q <= hpb_wr_addr;
      wr_data_q <= hpb_wr_data;
      wr_be_q   <= hpb_wr_byte_en;
    end
  // HOLD waits for the request to drop so a held request never writes twice
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = hpb_wr_req ? PEND : IDLE;
      PEND:    nxt = (!rd_req || starve_max) ? COMMIT : PEND;
      COMMIT:  nxt = DONE;
      DONE:    nxt = HOLD;
      HOLD:    nxt = hpb_wr_req ? HOLD : IDLE;
      default: nxt = IDLE;
    endcase
  end
`ifdef RCB_PARITY_EN
  logic perr;
  always_comb begin
    ram_wdata = '0;
    rd_data   = '0;
    perr      = 1'b0;
    for (int i = 0; i < BW; i++) begin
      ram_wdata[i*9 +: 9] = {byte_parity(wr_data_q[i*8 +: 8]), wr_data_q[i*8 +: 8]};
      rd_data[i*8 +: 8]   = ram_rdata[i*9 +: 8];
      perr |= ram_rdata[i*9+8] != byte_parity(ram_rdata[i*9 +: 8]);
    end
  end
  assign rd_parity_err = rd_valid && perr;
`else
  assign ram_wdata = wr_data_q;
  assign rd_data   = ram_rdata;
`endif
  rcb_sp_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(RW),
    .BE_WIDTH(BW),
    .RD_LATENCY(RD_LATENCY)
  ) u_ram (
    .clk(clk),
    .reset_n(reset_n),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .addr(wr_en ? wr_addr_q : rd_addr),
    .wr_data(ram_wdata),
    .wr_be(wr_be_q),
    .rd_valid(rd_valid),
    .rd_data(ram_rdata)
  );
endmodule
